demux4_16bit_reg: RTL and testbench
===================================

DEMUX4_16BIT_REG -- requirements
Module: demux4_16bit_reg

Interface
REQ-001 Parameter: WIDTH, default 16, data width of the input and of each output port.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  WIDTH  data word to be routed.
REQ-005 in_dest  input  2  destination port index, 0..3.
REQ-006 in_valid  input  1  in_data/in_dest are valid this cycle.
REQ-007 in_ready  output  1  block accepts the input this cycle.
REQ-008 out_data  output  4*WIDTH  port k data at bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  4  bit k set: port k holds an undelivered word.
REQ-010 out_ready  input  4  bit k set: port k consumer takes the word this cycle.
REQ-011 accept_count  output  8  running count of accepted input words.

Function
REQ-012 Each port k SHALL own a one-entry holding register (hold_k, WIDTH bits) whose occupancy flag drives out_valid[k]; out_data slice k SHALL be hold_k.
REQ-013 in_ready SHALL be combinational: (out_valid[in_dest] == 0) or (out_ready[in_dest] == 1).
REQ-014 in_ready SHALL depend only on the port selected by in_dest; the other ports SHALL NOT affect it.
REQ-015 Accept event: in_valid and in_ready high at a rising edge. On accept, hold_{in_dest} SHALL load in_data and out_valid[in_dest] SHALL be 1 from the next cycle.
REQ-016 Latency: a word accepted at edge N SHALL be visible on its port after edge N; the consumer may take it at edge N+1 at the earliest.
REQ-017 Drain event on port k: out_valid[k] and out_ready[k] high at a rising edge. Without a same-edge load of port k, out_valid[k] SHALL clear after that edge.
REQ-018 Same-edge drain and load of port k: hold_k SHALL take the new word and out_valid[k] SHALL stay 1. This sustains one word per cycle per port.
REQ-019 While out_valid[k]=1 and out_ready[k]=0, hold_k and out_valid[k] SHALL hold stable. A stalled port SHALL never be overwritten.
REQ-020 Drains on different ports SHALL proceed independently in the same cycle as each other and as an accept on any port.
REQ-021 When out_valid[k]=0, hold_k SHALL keep its last value; consumers ignore it.
REQ-022 With in_valid=0, the block SHALL ignore in_data and in_dest (including X) for state purposes; in_ready may still reflect in_dest.
REQ-023 accept_count SHALL increment by 1 on each accept event and SHALL wrap modulo 256 (255 -> 0).
REQ-024 out_ready[k] asserted while out_valid[k]=0 SHALL have no effect.
REQ-025 The block SHALL contain no combinational path from in_data to out_data; all outputs except in_ready SHALL be registered.

Reset
REQ-026 rst_n low SHALL immediately and asynchronously set out_valid=0, all hold_k=0 and accept_count=0.
REQ-027 Reset asserted mid-operation SHALL discard all held words; no word accepted before reset SHALL appear after reset.
REQ-028 While rst_n is low, no accept SHALL occur. in_ready SHALL evaluate to 1, since all ports are empty.
REQ-029 The first accept SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-030 After reset, send 0x1234 to dest 2 with out_ready=0: after the edge, out_valid=4'b0100, port 2 data = 0x1234, accept_count=1, and in_ready=0 while in_dest=2.
REQ-031 Stall hold: with port 2 full and out_ready[2]=0, present 0xBEEF to dest 2 for 5 cycles: port 2 stays 0x1234, accept_count unchanged; then assert out_ready[2]: 0xBEEF is accepted the same edge 0x1234 drains.
REQ-032 Streaming: out_ready=4'b1111, send 0x0001..0x0004 to dest 1 on back-to-back cycles: in_ready stays 1, port 1 shows each word for exactly one cycle, accept_count=4.
REQ-033 Independence: fill port 0 (stalled), then send 0xAAAA to dest 3 with out_ready[3]=1: the word is accepted and delivered; port 0 is unchanged.
REQ-034 Wrap: perform 256 accepts: accept_count returns to 0.
REQ-035 Reset mid-op: with ports 0 and 3 full, pulse rst_n low between edges: out_valid=0, hold data=0 and accept_count=0 immediately; old words never reappear.

Source files
------------

// File: rtl/demux4_16bit_reg.sv
// demux4_16bit_reg: routes one input word per cycle to one of four output
// ports, each backed by a single-entry holding register with valid/ready
// handshaking. A port accepts a new word when it is empty or is being
// drained on the same edge, so each port can sustain one word per cycle.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_data       word to route (WIDTH bits)
//   in_dest       destination port index 0..3
//   in_valid      in_data/in_dest valid this cycle
//   in_ready      combinational: selected port can take a word this cycle
//   out_data      port k data at [k*WIDTH +: WIDTH] (registered)
//   out_valid     bit k: port k holds an undelivered word (registered)
//   out_ready     bit k: port k consumer takes the word this cycle
//   accept_count  running count of accepted words, wraps at 256 (registered)
module demux4_16bit_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_dest,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [7:0]           accept_count
);

  localparam int unsigned NPORTS = 4;

  logic [WIDTH-1:0]  hold_q [NPORTS];
  logic [NPORTS-1:0] load;
  logic [NPORTS-1:0] valid_d;
  logic              accept;

  // Ready looks only at the addressed port: empty, or freed on this edge.
  assign in_ready = ~out_valid[in_dest] | out_ready[in_dest];
  assign accept   = in_valid & in_ready;

  // Per-port load strobes and next occupancy.
  always_comb begin
    load    = '0;
    valid_d = out_valid;
    for (int k = 0; k < NPORTS; k++) begin
      load[k]    = accept && (in_dest == 2'(k));
      // A load always leaves the port full; otherwise a drain empties it.
      valid_d[k] = load[k] | (out_valid[k] & ~out_ready[k]);
    end
  end

  // Occupancy flags and accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= '0;
      accept_count <= '0;
    end else begin
      out_valid <= valid_d;
      if (accept) begin
        accept_count <= accept_count + 8'd1;
      end
    end
  end

  // Holding registers: only written on a load, so stalled or empty ports keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPORTS; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (load[k]) begin
          hold_q[k] <= in_data;
        end
      end
    end
  end

  // Pack holding registers onto the output bus.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NPORTS; k++) begin
      out_data[k*WIDTH +: WIDTH] = hold_q[k];
    end
  end

endmodule

// File: tb/tb_demux4_16bit_reg.sv
// Scoreboard bench for demux4_16bit_reg: directed stimulus pushes each
// accepted word into its port queue; a negedge monitor checks every
// presented word against the queue head and pops it on delivery.
module tb_demux4_16bit_reg;

  localparam int unsigned W = 16;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic [1:0]     in_dest;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [7:0]     accept_count;

  logic [W-1:0] exp_q [4][$];
  int n_tests;
  int n_fail;

  demux4_16bit_reg #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_dest(in_dest),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .accept_count(accept_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid port must match its queue head; pop on delivery.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("spurious_valid_p%0d", k), 64'(out_valid[k]), 64'd0);
          end else begin
            chk($sformatf("data_p%0d", k), 64'(out_data[k*W +: W]), 64'(exp_q[k][0]));
            if (out_ready[k]) void'(exp_q[k].pop_front());
          end
        end else if (exp_q[k].size() != 0) begin
          chk($sformatf("lost_word_p%0d", k), 64'(out_valid[k]), 64'd1);
        end
      end
    end
  end

  // Present one word; waits (bounded) for in_ready, pushes expectation on accept.
  task automatic send(input logic [W-1:0] d, input logic [1:0] dst, output int waited);
    bit done = 0;
    waited = 0;
    in_data  = d;
    in_dest  = dst;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        exp_q[dst].push_back(d);
        done = 1;
      end else begin
        waited++;
        if (waited > 50) begin
          chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
          done = 1;
        end
        @(posedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    for (int k = 0; k < 4; k++) exp_q[k].delete();
  endtask

  initial begin
    int w;
    n_tests = 0;
    n_fail  = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_dest   = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_count", 64'(accept_count), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;

    // First word to port 2, consumer stalled.
    send(16'h1234, 2'd2, w);
    chk("first_wait", 64'(w), 64'd0);
    chk("first_out_valid", 64'(out_valid), 64'h4);
    chk("first_p2_data", 64'(out_data[2*W +: W]), 64'h1234);
    chk("first_count", 64'(accept_count), 64'd1);
    chk("first_in_ready_full", 64'(in_ready), 64'd0);

    // Stall: BEEF must not overwrite a held word.
    in_data  = 16'hBEEF;
    in_dest  = 2'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("stall_p2_data", 64'(out_data[2*W +: W]), 64'h1234);
    chk("stall_count", 64'(accept_count), 64'd1);
    // Release: drain 1234 and load BEEF on the same edge.
    out_ready[2] = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    exp_q[2].push_back(16'hBEEF);
    #1;
    in_valid = 1'b0;
    chk("release_p2_data", 64'(out_data[2*W +: W]), 64'hBEEF);
    chk("release_out_valid", 64'(out_valid), 64'h4);
    chk("release_count", 64'(accept_count), 64'd2);
    idle(1);
    chk("release_drained", 64'(out_valid), 64'h0);

    // Streaming to port 1, one word per cycle.
    out_ready = 4'b1111;
    for (int i = 1; i <= 4; i++) begin
      send(W'(i), 2'd1, w);
      chk($sformatf("stream_wait_%0d", i), 64'(w), 64'd0);
    end
    idle(2);
    chk("stream_count", 64'(accept_count), 64'd6);
    chk("stream_empty", 64'(out_valid), 64'h0);

    // Independence: stalled port 0 does not block port 3.
    out_ready = 4'b0000;
    send(16'h5555, 2'd0, w);
    out_ready = 4'b1000;
    send(16'hAAAA, 2'd3, w);
    chk("indep_wait", 64'(w), 64'd0);
    idle(2);
    chk("indep_p0_data", 64'(out_data[0 +: W]), 64'h5555);
    chk("indep_out_valid", 64'(out_valid), 64'h1);
    chk("indep_count", 64'(accept_count), 64'd8);

    // Reset mid-operation with ports 0 and 3 full.
    out_ready = 4'b0000;
    send(16'h7777, 2'd3, w);
    chk("prerst_out_valid", 64'(out_valid), 64'h9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_out_data", 64'(out_data), 64'h0);
    chk("midrst_count", 64'(accept_count), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h1);
    clear_q();
    rst_n = 1'b1;
    out_ready = 4'b1111;
    idle(3);
    chk("postrst_out_valid", 64'(out_valid), 64'h0);
    chk("postrst_count", 64'(accept_count), 64'h0);

    // Counter wrap: 256 accepts from a count of 0.
    for (int i = 0; i < 255; i++) begin
      send(W'(16'h1000 + i), 2'(i % 4), w);
    end
    chk("wrap_count_255", 64'(accept_count), 64'd255);
    send(16'hCAFE, 2'd0, w);
    chk("wrap_count_0", 64'(accept_count), 64'd0);
    idle(3);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("final_queue_p%0d", k), 64'(exp_q[k].size()), 64'd0);
    end
    chk("final_out_valid", 64'(out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
